// File: rtl/mcu_reset_sequencer_if.sv
// rtl/mcu_reset_sequencer_if.sv - lock/request inputs and reset/status outputs of the reset sequencer
interface mcu_reset_sequencer_if;
    logic       pll_locked;
    logic       sysresetreq;
    logic       wdt_reset_req;
    logic       cause_clr;
    logic       poresetn;
    logic       hresetn;
    logic       sys_ready;
    logic [2:0] reset_cause;
    logic [7:0] lock_lost_cnt;

    modport master (
        output pll_locked, sysresetreq, wdt_reset_req, cause_clr,
        input  poresetn, hresetn, sys_ready, reset_cause, lock_lost_cnt
    );

    modport slave (
        input  pll_locked, sysresetreq, wdt_reset_req, cause_clr,
        output poresetn, hresetn, sys_ready, reset_cause, lock_lost_cnt
    );
endinterface

// File: rtl/mcu_reset_sequencer.sv
// rtl/mcu_reset_sequencer.sv - sequences poresetn/hresetn from PLL lock, warm resets and cause tracking
module mcu_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int POR_TO_SYS_CYCLES  = 8,
    parameter int SYS_RST_CYCLES     = 32,
    parameter int CNT_W              = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    mcu_reset_sequencer_if.slave      bus
);

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        STABLE   = 3'd1,
        POR_REL  = 3'd2,
        RUN      = 3'd3,
        WARM     = 3'd4,
        WAIT_REQ = 3'd5
    } state_t;

    localparam logic [CNT_W:0]   STABLE_LIM = (CNT_W+1)'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_TO_SYS_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(SYS_RST_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q;
    logic             por_q, por_d;
    logic             run_q, run_d;
    logic [2:0]       cause_q, cause_d;
    logic [7:0]       lost_q, lost_d;
    logic             lock_s;
    logic             req;
    logic             lost;
    logic [2:0]       cause_set;

    assign lock_s = sync_q[1];
    assign req    = bus.sysresetreq | bus.wdt_reset_req;

    // Registers: lock synchroniser, FSM state, counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            state_q <= HOLD;
            cnt_q   <= '0;
            por_q   <= 1'b0;
            run_q   <= 1'b0;
            cause_q <= 3'b000;
            lost_q  <= 8'd0;
        end else begin
            sync_q  <= {sync_q[0], bus.pll_locked};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            por_q   <= por_d;
            run_q   <= run_d;
            cause_q <= cause_d;
            lost_q  <= lost_d;
        end
    end

    // Next state, counter, cause bits and lock-loss counting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lost      = 1'b0;
        cause_set = 3'b000;
        case (state_q)
            HOLD: begin
                if (lock_s) begin
                    cnt_d   = '0;
                    // The HOLD->STABLE edge already counts as the first stable cycle
                    state_d = (LOCK_STABLE_CYCLES <= 1) ? POR_REL : STABLE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (({1'b0, cnt_q} + (CNT_W+1)'(2)) >= STABLE_LIM) begin
                    state_d = POR_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            POR_REL: begin
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (cnt_q == POR_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cause_set[2:1] = {bus.wdt_reset_req, bus.sysresetreq};
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (req) begin
                    state_d = WARM;
                    cnt_d   = '0;
                end
            end
            WARM: begin
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (cnt_q == WARM_LAST) begin
                    // Requests already gone: release directly so the pulse is exactly SYS_RST_CYCLES
                    state_d = req ? WAIT_REQ : RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_REQ: begin
                if (!lock_s) begin
                    lost = 1'b1;
                end else if (!req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase

        if (lost) begin
            state_d      = HOLD;
            cnt_d        = '0;
            cause_set[0] = 1'b1;
        end

        cause_d = (bus.cause_clr ? 3'b000 : cause_q) | cause_set;
        lost_d  = (lost && lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;
        por_d   = (state_d == POR_REL) || (state_d == RUN) ||
                  (state_d == WARM)    || (state_d == WAIT_REQ);
        run_d   = (state_d == RUN);
    end

    assign bus.poresetn      = por_q;
    assign bus.hresetn       = run_q;
    assign bus.sys_ready     = run_q;
    assign bus.reset_cause   = cause_q;
    assign bus.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_mcu_reset_sequencer.sv
// tb/tb_mcu_reset_sequencer.sv - randomized self-checking bench for mcu_reset_sequencer
module tb_mcu_reset_sequencer;
    localparam int L = 16;
    localparam int P = 8;
    localparam int S = 32;

    logic clk;
    logic rst;
    mcu_reset_sequencer_if bus ();

    mcu_reset_sequencer #(
        .LOCK_STABLE_CYCLES (L),
        .POR_TO_SYS_CYCLES  (P),
        .SYS_RST_CYCLES     (S),
        .CNT_W              (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;
    int edge_n;

    // Reference model: lock history, stable streak and phase timers
    logic       ph1, ph2;
    int         streak;
    bit         m_por;
    bit         m_run;
    int         sys_wait;
    int         warm_left;
    bit         hold_req;
    logic [2:0] m_cause;
    int         m_lost;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph1 = 0; ph2 = 0; streak = 0; m_por = 0; m_run = 0;
        sys_wait = 0; warm_left = 0; hold_req = 0; m_cause = 0; m_lost = 0;
    endtask

    task automatic model_edge(input logic pl, input logic s, input logic w, input logic c);
        logic       lk;
        logic [2:0] set;
        lk  = ph2;
        ph2 = ph1;
        ph1 = pl;
        set = 3'b000;
        if (!m_por) begin
            streak = lk ? streak + 1 : 0;
            if (streak >= L) begin
                m_por    = 1;
                sys_wait = P;
            end
        end else if (!lk) begin
            if (m_lost < 255) m_lost++;
            set[0] = 1'b1;
            if (m_run) set[2:1] = {w, s};
            m_por = 0; m_run = 0; streak = 0; warm_left = 0; hold_req = 0;
        end else if (m_run) begin
            if (s || w) begin
                set[2:1]  = {w, s};
                m_run     = 0;
                warm_left = S;
            end
        end else if (warm_left > 0) begin
            warm_left--;
            if (warm_left == 0) begin
                if (s || w) hold_req = 1;
                else        m_run = 1;
            end
        end else if (hold_req) begin
            if (!(s || w)) begin
                hold_req = 0;
                m_run    = 1;
            end
        end else begin
            sys_wait--;
            if (sys_wait == 0) m_run = 1;
        end
        m_cause = (c ? 3'b000 : m_cause) | set;
    endtask

    task automatic compare_all();
        chk("outputs",
            {17'd0, bus.poresetn, bus.hresetn, bus.sys_ready, bus.reset_cause, bus.lock_lost_cnt},
            {17'd0, m_por, m_run, m_run, m_cause, 8'(m_lost)});
    endtask

    task automatic step(input logic pl, input logic s, input logic w, input logic c);
        bus.pll_locked    = pl;
        bus.sysresetreq   = s;
        bus.wdt_reset_req = w;
        bus.cause_clr     = c;
        @(posedge clk);
        model_edge(pl, s, w, c);
        edge_n++;
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n, input logic pl);
        rst = 1'b1;
        bus.pll_locked    = pl;
        bus.sysresetreq   = $urandom_range(0, 1);
        bus.wdt_reset_req = $urandom_range(0, 1);
        bus.cause_clr     = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_reset();
            #1;
            compare_all();
        end
        rst    = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        int por_e, hr_e, low_cnt, guard;
        logic s_r, w_r;
        n_vec = 0; n_bad = 0; edge_n = 0;
        rst = 1'b1;
        bus.pll_locked = 0; bus.sysresetreq = 0; bus.wdt_reset_req = 0; bus.cause_clr = 0;
        model_reset();

        // Power-up with lock already present: release edges
        do_reset(4, 1'b1);
        por_e = -1; hr_e = -1;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, 0);
            if (bus.poresetn && por_e < 0) por_e = edge_n;
            if (bus.hresetn && hr_e < 0)   hr_e  = edge_n;
        end
        chk("por_release_edge", por_e, 18);
        chk("sys_release_edge", hr_e, 26);

        // Lock glitch during STABLE restarts the stable count
        do_reset(4, 1'b1);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        por_e = -1;
        for (int i = 0; i < 50; i++) begin
            step(1, 0, 0, 0);
            if (bus.poresetn && por_e < 0) por_e = edge_n;
        end
        chk("glitch_por_edge", por_e, 12 + 2 + L);
        chk("glitch_ready", bus.sys_ready, 1);

        // One-cycle SYSRESETREQ pulse: hresetn low for exactly S cycles
        step(1, 1, 0, 0);
        low_cnt = bus.hresetn ? 0 : 1;
        guard = 0;
        while (!bus.hresetn && guard < 200) begin
            step(1, 0, 0, 0);
            if (!bus.hresetn) low_cnt++;
            guard++;
        end
        chk("warm_low_cycles", low_cnt, S);
        chk("warm_cause", bus.reset_cause, 3'b010);
        chk("warm_por_kept", bus.poresetn, 1);

        // Watchdog held high for 100 cycles
        step(1, 0, 0, 1);
        for (int i = 0; i < 100; i++) step(1, 0, 1, 0);
        chk("wdt_held_hres", bus.hresetn, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk("wdt_cause", bus.reset_cause, 3'b100);
        chk("wdt_back_run", bus.sys_ready, 1);

        // Lock loss in RUN, then relock
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("loss_cause0", bus.reset_cause[0], 1);
        chk("loss_cnt", bus.lock_lost_cnt, 1);
        for (int i = 0; i < 30; i++) step(1, 0, 0, 0);

        // Many lock-loss events saturate the counter
        for (int k = 0; k < 300; k++) begin
            guard = 0;
            while (!m_por && guard < 60) begin
                step(1, 0, 0, 0);
                guard++;
            end
            for (int i = 0; i < int'($urandom_range(0, 12)); i++) step(1, 0, 0, 0);
            for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        end
        chk("lost_cnt_sat", bus.lock_lost_cnt, 255);
        guard = 0;
        while (!bus.sys_ready && guard < 80) begin
            step(1, 0, 0, 0);
            guard++;
        end
        chk("ready_before_clr", bus.sys_ready, 1);
        step(1, 1, 0, 1);
        chk("clr_vs_set", bus.reset_cause, 3'b010);
        chk("clr_keeps_cnt", bus.lock_lost_cnt, 255);

        // Random traffic against the model
        do_reset(2, 1'($urandom_range(0, 1)));
        s_r = 0; w_r = 0;
        begin
            logic pl_r;
            pl_r = 1;
            for (int i = 0; i < 5000; i++) begin
                if ($urandom_range(0, 299) == 0) pl_r = ~pl_r;
                if (!pl_r && $urandom_range(0, 7) == 0) pl_r = 1;
                s_r = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 79) == 0) w_r = ~w_r;
                step(pl_r, s_r, w_r, $urandom_range(0, 49) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
